state_sequencer: RTL

//  Next-state engine of the multicycle RISC core: produces the StateID that the control decoder turns into mux selects and enables.

---
 rtl/state_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/state_sequencer.sv
// Next-state engine of the multicycle core: walks fetch/decode/execute/writeback
// per opcode and sequences the LM/SM register-mask transfer loop.
module state_sequencer #(
  parameter int STATE_W  = 5,
  parameter int IR_W     = 16,
  parameter int LSM_REGS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IR_W-1:0]    ir,
  input  logic               carry_flag,
  input  logic               zero_flag,
  input  logic               eq_flag,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state_id,
  output logic [2:0]         lsm_idx,
  output logic               lsm_step,
  output logic               instr_done,
  output logic               illegal_op
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),  S_ADD      = STATE_W'(1),  S_ADD_WB   = STATE_W'(2),
    S_ADI      = STATE_W'(3),  S_ADI_WB   = STATE_W'(4),  S_ADC_WB   = STATE_W'(5),
    S_ADZ_WB   = STATE_W'(6),  S_LINK     = STATE_W'(7),  S_NDU      = STATE_W'(8),
    S_NDU_WB   = STATE_W'(9),  S_NDC_WB   = STATE_W'(10), S_LHI      = STATE_W'(11),
    S_LHI_WB   = STATE_W'(12), S_PC_INC   = STATE_W'(13), S_DECODE   = STATE_W'(14),
    S_ADDR     = STATE_W'(15), S_SW_MEM   = STATE_W'(16), S_SM_MEM   = STATE_W'(17),
    S_LW_MEM   = STATE_W'(18), S_LW_WB    = STATE_W'(19), S_LSM_BASE = STATE_W'(20),
    S_LM_MEM   = STATE_W'(21), S_BEQ      = STATE_W'(22), S_BR_TGT   = STATE_W'(23),
    S_JLR      = STATE_W'(24)
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] lsm_idx_q, lsm_idx_d;
  logic       c_snap_q, c_snap_d, z_snap_q, z_snap_d;
  logic       lsm_step_q, lsm_step_d, instr_done_q, instr_done_d, illegal_op_q, illegal_op_d;

  logic [3:0]          opcode;
  logic [1:0]          cz;
  logic                cond;
  logic [LSM_REGS-1:0] mask;
  logic [3:0]          first_bit, next_bit;
  logic                unused_ir_bits;

  // Returns {found, index} of the lowest set mask bit at or above start.
  function automatic logic [3:0] find_bit(input logic [LSM_REGS-1:0] m, input int start);
    logic [3:0] r;
    r = '0;
    for (int i = LSM_REGS - 1; i >= 0; i--) begin
      if (i >= start && m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign opcode         = ir[IR_W-1 -: 4];
  assign cz             = ir[1:0];
  assign mask           = ir[LSM_REGS-1:0];
  assign cond           = (cz == 2'b10 && c_snap_q) || (cz == 2'b01 && z_snap_q);
  assign first_bit      = find_bit(mask, 0);
  assign next_bit       = find_bit(mask, int'(lsm_idx_q) + 1);
  assign unused_ir_bits = ^ir[IR_W-5:LSM_REGS];

  always_comb begin
    state_d      = state_q;
    lsm_idx_d    = lsm_idx_q;
    c_snap_d     = c_snap_q;
    z_snap_d     = z_snap_q;
    lsm_step_d   = 1'b0;
    instr_done_d = 1'b0;
    illegal_op_d = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_PC_INC;
      S_PC_INC: state_d = S_DECODE;
      S_DECODE: begin
        // Flags are frozen here so execute states ignore later flag updates.
        c_snap_d = carry_flag;
        z_snap_d = zero_flag;
        case (opcode)
          4'b0000: state_d = S_ADD;
          4'b0001: state_d = S_ADI;
          4'b0010: state_d = S_NDU;
          4'b0011: state_d = S_LHI;
          4'b0100, 4'b0101: state_d = S_ADDR;
          4'b0110, 4'b0111: state_d = S_LSM_BASE;
          4'b1100: state_d = S_BEQ;
          4'b1000, 4'b1001: state_d = S_LINK;
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_ADD: begin
        if (cz == 2'b00)                  state_d = S_ADD_WB;
        else if (cz == 2'b10 && c_snap_q) state_d = S_ADC_WB;
        else if (cz == 2'b01 && z_snap_q) state_d = S_ADZ_WB;
        else begin state_d = S_FETCH; instr_done_d = 1'b1; end
      end
      S_NDU: begin
        if (cz == 2'b00) state_d = S_NDU_WB;
        else if (cond)   state_d = S_NDC_WB;
        else begin state_d = S_FETCH; instr_done_d = 1'b1; end
      end
      S_ADI:  state_d = S_ADI_WB;
      S_LHI:  state_d = S_LHI_WB;
      S_ADDR: state_d = (opcode == 4'b0100) ? S_LW_MEM : S_SW_MEM;
      S_LW_MEM: if (mem_ready) state_d = S_LW_WB;
      S_SW_MEM: if (mem_ready) begin state_d = S_FETCH; instr_done_d = 1'b1; end
      S_LSM_BASE: begin
        if (!first_bit[3]) begin
          state_d      = S_FETCH;
          instr_done_d = 1'b1;
        end else begin
          lsm_idx_d = first_bit[2:0];
          state_d   = (opcode == 4'b0110) ? S_LM_MEM : S_SM_MEM;
        end
      end
      S_LM_MEM, S_SM_MEM: begin
        if (mem_ready) begin
          lsm_step_d = 1'b1;
          if (next_bit[3]) lsm_idx_d = next_bit[2:0];
          else begin state_d = S_FETCH; instr_done_d = 1'b1; end
        end
      end
      S_BEQ: begin
        if (eq_flag) state_d = S_BR_TGT;
        else begin state_d = S_FETCH; instr_done_d = 1'b1; end
      end
      S_LINK: state_d = (opcode == 4'b1000) ? S_BR_TGT : S_JLR;
      S_ADD_WB, S_ADI_WB, S_ADC_WB, S_ADZ_WB, S_NDU_WB, S_NDC_WB,
      S_LHI_WB, S_LW_WB, S_BR_TGT, S_JLR: begin
        state_d      = S_FETCH;
        instr_done_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      lsm_idx_q    <= '0;
      c_snap_q     <= 1'b0;
      z_snap_q     <= 1'b0;
      lsm_step_q   <= 1'b0;
      instr_done_q <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lsm_idx_q    <= lsm_idx_d;
      c_snap_q     <= c_snap_d;
      z_snap_q     <= z_snap_d;
      lsm_step_q   <= lsm_step_d;
      instr_done_q <= instr_done_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign state_id   = state_q;
  assign lsm_idx    = lsm_idx_q;
  assign lsm_step   = lsm_step_q;
  assign instr_done = instr_done_q;
  assign illegal_op = illegal_op_q;

endmodule
